// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin arbiter that collects unit-clause literals from
// NUM_ENG process engines and feeds them, one per cycle, into the unit clause
// queue through a single output stage register.
//
// Literal encoding: bit 0 is the polarity, bits [LW-1:1] are the variable index.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   flush      synchronous clear of the arbitration state (backtrack)
//   eng_valid  per-engine unit-clause request
//   eng_uc     per-engine literal, meaningful when the matching eng_valid bit is high
//   eng_ready  one-hot grant; a request is consumed when eng_valid[i] & eng_ready[i]
//   ucq_full   full flag from the unit clause queue
//   ucq_push   push strobe to the unit clause queue
//   uca2ucq    literal to the unit clause queue, valid with ucq_push
//   conflict   sticky flag: complementary literals seen in the same cycle
//   push_cnt   saturating count of literals pushed

`ifndef UC_LENGTH
`define UC_LENGTH 256
`endif

module uc_arbiter #(
  parameter int unsigned NUM_ENG = 4,
  parameter int unsigned LW      = $clog2(`UC_LENGTH),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_ENG-1:0]          eng_valid,
  input  logic [NUM_ENG-1:0][LW-1:0]  eng_uc,
  output logic [NUM_ENG-1:0]          eng_ready,
  input  logic                        ucq_full,
  output logic                        ucq_push,
  output logic [LW-1:0]               uca2ucq,
  output logic                        conflict,
  output logic [CNT_W-1:0]            push_cnt
);

  localparam int unsigned PW = $clog2(NUM_ENG);

  // State
  logic             out_vld_r, out_vld_d;
  logic [LW-1:0]    out_lit_r, out_lit_d;
  logic             last_vld_r, last_vld_d;
  logic [LW-1:0]    last_lit_r, last_lit_d;
  logic [PW-1:0]    rr_ptr_r, rr_ptr_d;
  logic             conflict_r, conflict_d;
  logic [CNT_W-1:0] push_cnt_r, push_cnt_d;

  // Arbitration signals
  logic          can_accept;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic [LW-1:0] grant_lit;
  logic          dup;
  logic          load;
  logic          conflict_hit;

  assign uca2ucq  = out_lit_r;
  assign conflict = conflict_r;
  assign push_cnt = push_cnt_r;

  // Push, accept and round-robin grant
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    sum  = '0;
    cand = '0;

    // rst and flush both suppress the push so a staged literal is dropped.
    ucq_push   = out_vld_r && !ucq_full && !rst && !flush;
    // Stage is free if empty or if it drains this very cycle (no bubble).
    can_accept = !out_vld_r || ucq_push;

    grant_vld = 1'b0;
    grant_idx = '0;
    if (can_accept && !flush && !rst) begin
      for (int unsigned k = 0; k < NUM_ENG; k++) begin
        // rr_ptr_r and k are both below NUM_ENG, so one subtraction wraps.
        sum = {1'b0, rr_ptr_r} + (PW+1)'(k);
        if (sum >= (PW+1)'(NUM_ENG)) begin
          sum = sum - (PW+1)'(NUM_ENG);
        end
        cand = sum[PW-1:0];
        if (!grant_vld && eng_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end

    eng_ready = '0;
    if (grant_vld) begin
      eng_ready[grant_idx] = 1'b1;
    end

    grant_lit = eng_uc[grant_idx];
    // A repeat of the last accepted literal is acknowledged but not re-queued.
    dup       = grant_vld && last_vld_r && (grant_lit == last_lit_r);
    load      = grant_vld && !dup;
  end

  // Complementary-literal detection; independent of grant and backpressure.
  always_comb begin
    conflict_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      for (int unsigned j = i + 1; j < NUM_ENG; j++) begin
        // Same variable, opposite polarity <=> literals differ only in bit 0.
        if (eng_valid[PW'(i)] && eng_valid[PW'(j)] &&
            ((eng_uc[PW'(i)] ^ eng_uc[PW'(j)]) == LW'(1))) begin
          conflict_hit = 1'b1;
        end
      end
      if (eng_valid[PW'(i)] && last_vld_r &&
          (eng_uc[PW'(i)] == (last_lit_r ^ LW'(1)))) begin
        conflict_hit = 1'b1;
      end
    end
  end

  // Next-state
  always_comb begin
    out_vld_d  = out_vld_r;
    out_lit_d  = out_lit_r;
    last_vld_d = last_vld_r;
    last_lit_d = last_lit_r;
    rr_ptr_d   = rr_ptr_r;
    conflict_d = conflict_r;
    push_cnt_d = push_cnt_r;

    if (flush) begin
      out_vld_d  = 1'b0;
      last_vld_d = 1'b0;
      conflict_d = 1'b0;
      rr_ptr_d   = '0;
    end else begin
      if (ucq_push) begin
        out_vld_d = 1'b0;
      end
      if (load) begin
        out_vld_d  = 1'b1;
        out_lit_d  = grant_lit;
        last_vld_d = 1'b1;
        last_lit_d = grant_lit;
      end
      if (grant_vld) begin
        rr_ptr_d = (grant_idx == PW'(NUM_ENG - 1)) ? '0 : grant_idx + PW'(1);
      end
      if (conflict_hit) begin
        conflict_d = 1'b1;
      end
    end

    if (ucq_push && (push_cnt_r != '1)) begin
      push_cnt_d = push_cnt_r + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_lit_r  <= '0;
      last_vld_r <= 1'b0;
      last_lit_r <= '0;
      rr_ptr_r   <= '0;
      conflict_r <= 1'b0;
      push_cnt_r <= '0;
    end else begin
      out_vld_r  <= out_vld_d;
      out_lit_r  <= out_lit_d;
      last_vld_r <= last_vld_d;
      last_lit_r <= last_lit_d;
      rr_ptr_r   <= rr_ptr_d;
      conflict_r <= conflict_d;
      push_cnt_r <= push_cnt_d;
    end
  end

endmodule

// File: tb/tb_uc_arbiter.sv
// Testbench for uc_arbiter: directed vectors; expected pushed literals go into
// a queue that a negedge monitor drains whenever ucq_push is high.

module tb_uc_arbiter;

  localparam int unsigned NE = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic                   ucq_full = 1'b0;
  logic [NE-1:0]          eng_valid = '0;
  logic [NE-1:0][LW-1:0]  eng_uc = '0;
  logic [NE-1:0]          eng_ready;
  logic                   ucq_push;
  logic [LW-1:0]          uca2ucq;
  logic                   conflict;
  logic [CW-1:0]          push_cnt;

  int checks = 0;
  int failures = 0;
  logic [LW-1:0] exp_q[$];

  uc_arbiter #(
    .NUM_ENG (NE),
    .LW      (LW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .eng_valid (eng_valid),
    .eng_uc    (eng_uc),
    .eng_ready (eng_ready),
    .ucq_full  (ucq_full),
    .ucq_push  (ucq_push),
    .uca2ucq   (uca2ucq),
    .conflict  (conflict),
    .push_cnt  (push_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every push must match the oldest expected literal.
  always @(negedge clk) begin
    if (ucq_push === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push: got 0x%0h expected no push", uca2ucq);
      end else begin
        check("push_lit", 32'(uca2ucq), 32'(exp_q.pop_front()));
      end
    end
  end

  // Apply inputs just after a rising edge; they are sampled at the next one.
  // Returns 2 time units later so combinational outputs can be checked.
  task automatic cyc(input logic [NE-1:0] v, input logic full, input logic fl, input logic r);
    @(posedge clk);
    #1;
    eng_valid = v;
    ucq_full  = full;
    flush     = fl;
    rst       = r;
    #2;
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    eng_uc = {8'd8, 8'd6, 8'd4, 8'd2};

    // Reset: requests present during the rst cycle are not granted.
    cyc(4'hF, 1'b0, 1'b0, 1'b1);
    check("rst_ready", 32'(eng_ready), 32'h0);
    check("rst_push", 32'(ucq_push), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("rst_ready_after", 32'(eng_ready), 32'h0);
    check("rst_push_after", 32'(ucq_push), 32'h0);
    check("rst_lit", 32'(uca2ucq), 32'h0);
    check("rst_cnt", 32'(push_cnt), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);

    // Fairness: 0,1,2,3,0,1,2,3 with one push per cycle.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(4'hF, 1'b0, 1'b0, 1'b0);
      check("fair_ready", 32'(eng_ready), 32'h1 << (k % 4));
      check("fair_cnt", 32'(push_cnt), (k > 0) ? 32'(k - 1) : 32'h0);
      exp_q.push_back(LW'(2 * ((k % 4) + 1)));
    end
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("fair_drain_push", 32'(ucq_push), 32'h1);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("fair_cnt_final", 32'(push_cnt), 32'd8);

    // Backpressure: 6 held for 3 full cycles, then pushed while 2 is granted.
    do_reset();
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    check("bp_grant", 32'(eng_ready), 32'b0100);
    exp_q.push_back(8'd6);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0001, 1'b1, 1'b0, 1'b0);
      check("bp_hold_lit", 32'(uca2ucq), 32'd6);
      check("bp_no_push", 32'(ucq_push), 32'h0);
      check("bp_no_ready", 32'(eng_ready), 32'h0);
    end
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    check("bp_release_push", 32'(ucq_push), 32'h1);
    check("bp_release_grant", 32'(eng_ready), 32'b0001);
    exp_q.push_back(8'd2);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("bp_cnt", 32'(push_cnt), 32'd2);

    // Duplicate: engine 1 sends 10 twice; both acked, one push.
    do_reset();
    eng_uc = {8'd8, 8'd6, 8'd10, 8'd2};
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    check("dup_ack1", 32'(eng_ready), 32'b0010);
    exp_q.push_back(8'd10);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    check("dup_ack2", 32'(eng_ready), 32'b0010);
    check("dup_first_push", 32'(ucq_push), 32'h1);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("dup_no_second_push", 32'(ucq_push), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("dup_cnt", 32'(push_cnt), 32'd1);

    // Conflict: 12 and 13 together; then flush drops a staged literal.
    do_reset();
    eng_uc = {8'd8, 8'd13, 8'd4, 8'd12};
    cyc(4'b0101, 1'b0, 1'b0, 1'b0);
    check("cf_pre", 32'(conflict), 32'h0);
    check("cf_grant", 32'(eng_ready), 32'b0001);
    exp_q.push_back(8'd12);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("cf_set", 32'(conflict), 32'h1);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    check("cf_sticky", 32'(conflict), 32'h1);
    check("cf_grant1", 32'(eng_ready), 32'b0010);
    cyc(4'b0010, 1'b0, 1'b1, 1'b0);
    check("fl_ready", 32'(eng_ready), 32'h0);
    check("fl_push", 32'(ucq_push), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("fl_conflict", 32'(conflict), 32'h0);
    check("fl_push_after", 32'(ucq_push), 32'h0);
    check("fl_cnt_kept", 32'(push_cnt), 32'd1);
    eng_uc = {8'd8, 8'd6, 8'd4, 8'd2};
    cyc(4'hF, 1'b0, 1'b0, 1'b0);
    check("fl_ptr_zero", 32'(eng_ready), 32'b0001);
    exp_q.push_back(8'd2);
    // Complement of the last accepted literal also raises conflict.
    eng_uc[3] = 8'd3;
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    check("cf_last_grant", 32'(eng_ready), 32'b1000);
    exp_q.push_back(8'd3);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("cf_last_set", 32'(conflict), 32'h1);
    cyc('0, 1'b0, 1'b0, 1'b0);

    // Reset mid-transfer: staged 2 must never be pushed.
    do_reset();
    eng_uc = {8'd8, 8'd6, 8'd4, 8'd2};
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    check("mr_grant", 32'(eng_ready), 32'b0001);
    cyc('0, 1'b1, 1'b0, 1'b0);
    check("mr_held", 32'(uca2ucq), 32'd2);
    check("mr_full_no_push", 32'(ucq_push), 32'h0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b1);
    check("mr_rst_push", 32'(ucq_push), 32'h0);
    check("mr_rst_ready", 32'(eng_ready), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("mr_after_push", 32'(ucq_push), 32'h0);
    check("mr_after_lit", 32'(uca2ucq), 32'h0);
    check("mr_after_cnt", 32'(push_cnt), 32'h0);
    check("mr_after_conflict", 32'(conflict), 32'h0);

    // Saturation: 20 pushes into a 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cyc(4'hF, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(LW'(2 * ((k % 4) + 1)));
      if (k >= 16) begin
        check("sat_cnt_hold", 32'(push_cnt), 32'd15);
      end
    end
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt_final", 32'(push_cnt), 32'd15);

    cyc('0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_arbiter.md
UC_ARBITER -- requirements
Module: uc_arbiter

Interface
REQ-001 Parameter NUM_ENG, default 4, number of requesting process engines (2..16).
REQ-002 Parameter LW, default $clog2(`UC_LENGTH), literal width; literal encoding is LSB = polarity and [LW-1:1] = variable index.
REQ-003 Parameter CNT_W, default 16, width of the push counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous clear of arbitration state, for backtrack.
REQ-007 eng_valid  input  NUM_ENG  per-engine unit-clause request.
REQ-008 eng_uc  input  NUM_ENG x LW  per-engine literal; sampled only when the matching eng_valid bit is high.
REQ-009 eng_ready  output  NUM_ENG  one-hot grant; a request is consumed on a cycle with eng_valid[i] and eng_ready[i] both high.
REQ-010 ucq_full  input  1  full flag from the unit clause queue.
REQ-011 ucq_push  output  1  push strobe to the unit clause queue.
REQ-012 uca2ucq  output  LW  literal to the unit clause queue; valid when ucq_push is high.
REQ-013 conflict  output  1  sticky flag for complementary literals seen in the same cycle.
REQ-014 push_cnt  output  CNT_W  count of literals pushed.

Function
REQ-015 The block SHALL hold one output stage register (out_vld_r, out_lit_r) that drives uca2ucq = out_lit_r.
REQ-016 The block SHALL drive ucq_push = out_vld_r && !ucq_full combinationally.
REQ-017 The stage SHALL accept a grant when !out_vld_r || ucq_push (stage empty or draining this cycle).
REQ-018 When the stage can accept, flush is low and rst is low, the block SHALL grant round-robin.
  - search order starts at rr_ptr_r, wraps modulo NUM_ENG
  - the first valid engine wins; eng_ready is one-hot on the winner, otherwise all zero.
REQ-019 On a grant to engine w, rr_ptr_r SHALL become (w+1) mod NUM_ENG; with no grant, rr_ptr_r SHALL hold.
REQ-020 Latency: a literal granted at edge k SHALL appear with ucq_push high in cycle k+1 unless ucq_full; it SHALL then hold until a push occurs.
REQ-021 Sustained throughput with ucq_full low SHALL be one literal per cycle.
REQ-022 Duplicate filtering:
  - if the granted literal equals last_lit_r and last_vld_r is high, the request SHALL still be acknowledged (eng_ready high)
  - the stage SHALL NOT load, and out_vld_r SHALL clear if it drained this cycle
  - otherwise last_lit_r SHALL take the granted literal and last_vld_r SHALL be set.
REQ-023 conflict SHALL set when, in one cycle, two valid requests i≠j have equal variable index and differing polarity, or a valid request is the complement of last_lit_r with last_vld_r high; it SHALL stay set until rst or flush.
REQ-024 push_cnt SHALL increment by one on each cycle with ucq_push high and SHALL saturate at 2^CNT_W-1.
REQ-025 With ucq_full high and out_vld_r high, eng_ready SHALL be all zero and all state SHALL hold, except the conflict check, which SHALL still run.
REQ-026 flush SHALL take priority over grants.
  - in the flush cycle eng_ready = 0 and ucq_push = 0
  - next state: out_vld_r = 0, last_vld_r = 0, conflict = 0, rr_ptr_r = 0
  - push_cnt SHALL be kept.
REQ-027 Simultaneous push and grant in the same cycle SHALL leave the stage loaded with the new literal, with no bubble.

Reset
REQ-028 On rst high at an edge, the block SHALL set out_vld_r = 0, out_lit_r = 0, last_vld_r = 0, last_lit_r = 0, rr_ptr_r = 0, conflict = 0 and push_cnt = 0.
REQ-029 During the rst cycle, eng_ready SHALL be 0 and ucq_push SHALL be 0.
REQ-030 rst asserted mid-transfer SHALL discard the staged literal without pushing it.

Verification
REQ-031 Fairness: NUM_ENG=4, all valid with literals 2,4,6,8 held, ucq_full=0 -> grants to engines 0,1,2,3,0..., pushes 2,4,6,8,2... each one cycle after its grant; push_cnt increments every cycle.
REQ-032 Backpressure: stage holding literal 6, ucq_full=1 for 3 cycles -> uca2ucq stays 6, ucq_push=0, eng_ready=0; on ucq_full=0 -> push 6 and accept a new grant in the same cycle.
REQ-033 Duplicate: engine 1 sends 10 then 10 again -> both acknowledged, exactly one push of 10, push_cnt += 1.
REQ-034 Conflict: engines 0 and 2 request 12 and 13 in the same cycle -> conflict=1 next cycle and stays 1; flush -> conflict=0, rr_ptr_r=0, push_cnt unchanged.
REQ-035 Reset mid-operation: stage loaded and ucq_full=1, rst pulsed -> ucq_push never asserts for the staged literal, all outputs 0 after the edge.
REQ-036 Count saturation: CNT_W=4, 20 pushes -> push_cnt reaches 15 and holds.
